// File: rtl/irq_arbiter_if.sv
// CSR access and interrupt handshake between the core and irq_arbiter.
// The master is the core side and the slave is the arbiter.
interface irq_arbiter_if;
    logic        csr_we;
    logic [1:0]  csr_sel;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        irq_ack;
    logic        irq_req;
    logic [3:0]  irq_cause;
    logic        irq_to_s;

    modport master (
        output csr_we, csr_sel, csr_wdata, irq_ack,
        input  csr_rdata, irq_req, irq_cause, irq_to_s
    );

    modport slave (
        input  csr_we, csr_sel, csr_wdata, irq_ack,
        output csr_rdata, irq_req, irq_cause, irq_to_s
    );
endinterface

// File: rtl/irq_arbiter.sv
// M/S-mode interrupt arbiter: mie/mip/mideleg CSRs, fixed-priority pick and a
// registered request handshake. Define IRQ_ARBITER_SUPERVISOR_EN for S-mode sources/delegation.
module irq_arbiter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         msip,
    input  logic         mtip,
    input  logic         meip,
    input  logic         mstatus_mie,
    input  logic         mstatus_sie,
    input  logic [1:0]   priv,
    irq_arbiter_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [11:0] M_BITS = 12'h888;
`ifdef IRQ_ARBITER_SUPERVISOR_EN
    localparam logic [11:0] S_BITS = 12'h222;
`else
    localparam logic [11:0] S_BITS = 12'h000;
`endif

    logic [SYNC_STAGES-1:0] meip_sync_reg;
    logic [11:0]            mie_reg;
    logic [11:0]            mip_sw_reg;
    logic [11:0]            mideleg_reg;
    logic [1:0]             state_reg,  state_next;
    logic [3:0]             cause_reg,  cause_next;
    logic                   to_s_reg,   to_s_next;

    logic [11:0] mip_view;
    logic [11:0] active;
    logic [11:0] eligible;
    logic        m_elig_en;
    logic        s_elig_en;
    logic        win_valid;
    logic [3:0]  win_cause;
    logic        win_to_s;
    logic        unused_inputs;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            meip_sync_reg <= '0;
        end else begin
            meip_sync_reg <= {meip_sync_reg[SYNC_STAGES-2:0], meip};
        end
    end

    // Register writes take effect at the edge, so arbitration in the same
    // cycle naturally sees the pre-write values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mie_reg     <= '0;
            mip_sw_reg  <= '0;
            mideleg_reg <= '0;
        end else if (bus.csr_we) begin
            case (bus.csr_sel)
                2'd0:    mie_reg     <= bus.csr_wdata[11:0] & (M_BITS | S_BITS);
                2'd1:    mip_sw_reg  <= bus.csr_wdata[11:0] & S_BITS;
                2'd2:    mideleg_reg <= bus.csr_wdata[11:0] & S_BITS;
                default: ;
            endcase
        end
    end

    always_comb begin
        mip_view     = mip_sw_reg & S_BITS;
        mip_view[3]  = msip;
        mip_view[7]  = mtip;
        mip_view[11] = meip_sync_reg[SYNC_STAGES-1];
    end

    always_comb begin
        bus.csr_rdata = 32'd0;
        case (bus.csr_sel)
            2'd0:    bus.csr_rdata = {20'd0, mie_reg};
            2'd1:    bus.csr_rdata = {20'd0, mip_view};
            2'd2:    bus.csr_rdata = {20'd0, mideleg_reg};
            default: bus.csr_rdata = 32'd0;
        endcase
    end

    assign m_elig_en = (priv != 2'd3) || mstatus_mie;
`ifdef IRQ_ARBITER_SUPERVISOR_EN
    assign s_elig_en     = (priv == 2'd0) || ((priv == 2'd1) && mstatus_sie);
    assign unused_inputs = ^bus.csr_wdata[31:12];
`else
    assign s_elig_en     = 1'b0;
    assign unused_inputs = ^{bus.csr_wdata[31:12], mstatus_sie};
`endif

    assign active   = mip_view & mie_reg;
    assign eligible = (active & ~mideleg_reg & {12{m_elig_en}})
                    | (active &  mideleg_reg & {12{s_elig_en}});
    assign win_valid = |eligible;

    // Fixed priority, highest first: 11, 3, 7, 9, 1, 5.
    always_comb begin
        win_cause = 4'd0;
        win_to_s  = 1'b0;
        if (eligible[11]) begin
            win_cause = 4'd11;
            win_to_s  = mideleg_reg[11];
        end else if (eligible[3]) begin
            win_cause = 4'd3;
            win_to_s  = mideleg_reg[3];
        end else if (eligible[7]) begin
            win_cause = 4'd7;
            win_to_s  = mideleg_reg[7];
        end else if (eligible[9]) begin
            win_cause = 4'd9;
            win_to_s  = mideleg_reg[9];
        end else if (eligible[1]) begin
            win_cause = 4'd1;
            win_to_s  = mideleg_reg[1];
        end else if (eligible[5]) begin
            win_cause = 4'd5;
            win_to_s  = mideleg_reg[5];
        end
    end

    // The cause is latched only on entry to REQ and held until HOLD, so a
    // late higher-priority source waits for the next arbitration round.
    always_comb begin
        state_next = state_reg;
        cause_next = cause_reg;
        to_s_next  = to_s_reg;
        case (state_reg)
            ST_IDLE: begin
                if (win_valid) begin
                    state_next = ST_REQ;
                    cause_next = win_cause;
                    to_s_next  = win_to_s;
                end
            end
            ST_REQ: begin
                if (bus.irq_ack) begin
                    state_next = ST_HOLD;
                end else if (!win_valid) begin
                    state_next = ST_IDLE;
                end
            end
            ST_HOLD: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= ST_IDLE;
            cause_reg <= 4'd0;
            to_s_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cause_reg <= cause_next;
            to_s_reg  <= to_s_next;
        end
    end

    assign bus.irq_req   = (state_reg == ST_REQ);
    assign bus.irq_cause = cause_reg;
    assign bus.irq_to_s  = to_s_reg;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter (SYNC_STAGES=3): expected requests are queued by
// the stimulus and checked by a monitor on each new irq_req.
module tb_irq_arbiter;

`ifdef IRQ_ARBITER_SUPERVISOR_EN
    localparam logic [31:0] S_EXP = 32'h222;
`else
    localparam logic [31:0] S_EXP = 32'h000;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic       msip, mtip, meip;
    logic       mstatus_mie, mstatus_sie;
    logic [1:0] priv;

    irq_arbiter_if bus ();

    irq_arbiter #(.SYNC_STAGES(3)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .msip        (msip),
        .mtip        (mtip),
        .meip        (meip),
        .mstatus_mie (mstatus_mie),
        .mstatus_sie (mstatus_sie),
        .priv        (priv),
        .bus         (bus.slave)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [4:0] exp_q[$];
    logic       prev_req = 1'b0;

    // Monitor: every new request pops one {to_s, cause} expectation.
    always @(negedge clk) begin
        logic [4:0] e;
        if (bus.irq_req && !prev_req) begin
            $display("[TB] request cause=%0d to_s=%0d", bus.irq_cause, bus.irq_to_s);
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_req: got cause=%0d to_s=%0d, required no request",
                         bus.irq_cause, bus.irq_to_s);
            end else begin
                e = exp_q.pop_front();
                if ({bus.irq_to_s, bus.irq_cause} !== e) begin
                    n_fail++;
                    $display("FAIL req_cause: got cause=%0d to_s=%0d, required cause=%0d to_s=%0d",
                             bus.irq_cause, bus.irq_to_s, e[3:0], e[4]);
                end
            end
        end
        prev_req = bus.irq_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic csr_write(input logic [1:0] sel, input logic [31:0] data);
        bus.csr_we    = 1'b1;
        bus.csr_sel   = sel;
        bus.csr_wdata = data;
        tick();
        bus.csr_we    = 1'b0;
    endtask

    task automatic csr_read(input string name, input logic [1:0] sel, input logic [31:0] req);
        bus.csr_sel = sel;
        #1;
        check(name, bus.csr_rdata, req);
    endtask

    task automatic ack_write(input logic [1:0] sel, input logic [31:0] data);
        bus.irq_ack   = 1'b1;
        bus.csr_we    = 1'b1;
        bus.csr_sel   = sel;
        bus.csr_wdata = data;
        tick();
        bus.irq_ack   = 1'b0;
        bus.csr_we    = 1'b0;
    endtask

    task automatic wait_req(input string name, input int budget);
        int n = 0;
        while (!bus.irq_req && n < budget) begin
            tick();
            n++;
        end
        n_tests++;
        if (!bus.irq_req) begin
            n_fail++;
            $display("FAIL %s: irq_req=0 after %0d cycles, required 1", name, budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        msip = 1'b0; mtip = 1'b0; meip = 1'b0;
        mstatus_mie = 1'b0; mstatus_sie = 1'b0; priv = 2'd3;
        bus.csr_we = 1'b0; bus.csr_sel = 2'd0; bus.csr_wdata = 32'd0; bus.irq_ack = 1'b0;
        repeat (3) tick();
        check("rst_req", {31'd0, bus.irq_req}, 32'd0);
        check("rst_cause", {28'd0, bus.irq_cause}, 32'd0);
        check("rst_to_s", {31'd0, bus.irq_to_s}, 32'd0);
        csr_read("rst_mie", 2'd0, 32'd0);
        csr_read("rst_mip", 2'd1, 32'd0);
        csr_read("rst_mideleg", 2'd2, 32'd0);
        resetn = 1'b1;
        tick();

        // Timer interrupt: one-cycle latency, ack, HOLD gap.
        mstatus_mie = 1'b1; priv = 2'd3;
        csr_write(2'd0, 32'h80);
        csr_read("a_mie", 2'd0, 32'h80);
        exp_q.push_back({1'b0, 4'd7});
        mtip = 1'b1;
        tick();
        check("a_latency", {31'd0, bus.irq_req}, 32'd1);
        bus.irq_ack = 1'b1; mtip = 1'b0;
        tick();
        bus.irq_ack = 1'b0;
        check("a_hold", {31'd0, bus.irq_req}, 32'd0);
        tick();
        check("a_idle", {31'd0, bus.irq_req}, 32'd0);
        csr_write(2'd0, 32'h0);

        // All three M sources pending: priority order 11, 3, 7; ack+write same cycle.
        msip = 1'b1; mtip = 1'b1; meip = 1'b1;
        repeat (5) tick();
        exp_q.push_back({1'b0, 4'd11});
        exp_q.push_back({1'b0, 4'd3});
        exp_q.push_back({1'b0, 4'd7});
        csr_write(2'd0, 32'h888);
        wait_req("b_req11", 3);
        ack_write(2'd0, 32'h088);
        check("b_ack_drop", {31'd0, bus.irq_req}, 32'd0);
        wait_req("b_req3", 4);
        ack_write(2'd0, 32'h080);
        wait_req("b_req7", 4);
        ack_write(2'd0, 32'h0);
        msip = 1'b0; mtip = 1'b0; meip = 1'b0;
        repeat (5) tick();
        check("b_quiet", {31'd0, bus.irq_req}, 32'd0);

        // Cause held in REQ when a higher-priority source arrives.
        mtip = 1'b1;
        exp_q.push_back({1'b0, 4'd7});
        exp_q.push_back({1'b0, 4'd3});
        csr_write(2'd0, 32'h888);
        wait_req("s_req7", 3);
        msip = 1'b1;
        repeat (2) tick();
        check("s_stable_req", {31'd0, bus.irq_req}, 32'd1);
        check("s_stable_cause", {28'd0, bus.irq_cause}, 32'd7);
        mtip = 1'b0;
        ack_write(2'd0, 32'h008);
        wait_req("s_req3", 4);
        msip = 1'b0;
        ack_write(2'd0, 32'h0);
        tick();

        // M-mode global disable, then drop to U-mode; ack outside REQ ignored.
        priv = 2'd3; mstatus_mie = 1'b0; msip = 1'b1;
        csr_write(2'd0, 32'h8);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("c_masked", {31'd0, bus.irq_req}, 32'd0);
        end
        priv = 2'd0;
        exp_q.push_back({1'b0, 4'd3});
        tick();
        check("c_upriv", {31'd0, bus.irq_req}, 32'd1);
        bus.irq_ack = 1'b1; msip = 1'b0;
        tick();
        check("c_hold", {31'd0, bus.irq_req}, 32'd0);
        tick();
        check("c_idle_ack", {31'd0, bus.irq_req}, 32'd0);
        msip = 1'b1;
        exp_q.push_back({1'b0, 4'd3});
        tick();
        check("c_ack_ignored", {31'd0, bus.irq_req}, 32'd1);
        tick();
        bus.irq_ack = 1'b0; msip = 1'b0;
        check("c_ack2", {31'd0, bus.irq_req}, 32'd0);
        csr_write(2'd0, 32'h0);
        priv = 2'd3; mstatus_mie = 1'b1;

        // Withdrawal by mie write; read-only mip bits; CSR masks.
        mtip = 1'b1;
        exp_q.push_back({1'b0, 4'd7});
        csr_write(2'd0, 32'h80);
        wait_req("d_req7", 3);
        csr_write(2'd0, 32'h0);
        check("d_prewrite", {31'd0, bus.irq_req}, 32'd1);
        tick();
        check("d_withdraw", {31'd0, bus.irq_req}, 32'd0);
        csr_write(2'd1, 32'hFFFF_FFFF);
        csr_read("d_mip_ro", 2'd1, 32'h80 | S_EXP);
        mstatus_mie = 1'b0; mtip = 1'b0;
        csr_write(2'd0, 32'hFFFF_FFFF);
        csr_read("d_mie_mask", 2'd0, 32'h888 | S_EXP);
        csr_write(2'd2, 32'hFFFF_FFFF);
        csr_read("d_mideleg_mask", 2'd2, S_EXP);
        csr_write(2'd3, 32'hFFFF_FFFF);
        csr_read("d_reserved", 2'd3, 32'h0);
        csr_write(2'd0, 32'h0);
        csr_write(2'd1, 32'h0);
        csr_write(2'd2, 32'h0);
        check("d_no_req", {31'd0, bus.irq_req}, 32'd0);
        mstatus_mie = 1'b1;

        // Delegated supervisor interrupt.
        mstatus_mie = 1'b0; priv = 2'd1; mstatus_sie = 1'b1;
        csr_write(2'd2, 32'h20);
        csr_write(2'd0, 32'h20);
`ifdef IRQ_ARBITER_SUPERVISOR_EN
        exp_q.push_back({1'b1, 4'd5});
        csr_write(2'd1, 32'h20);
        wait_req("e_req5", 3);
        check("e_to_s", {31'd0, bus.irq_to_s}, 32'd1);
        ack_write(2'd1, 32'h0);
        tick();
        check("e_done", {31'd0, bus.irq_req}, 32'd0);
        priv = 2'd3;
        csr_write(2'd1, 32'h20);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("e_mpriv_blocked", {31'd0, bus.irq_req}, 32'd0);
        end
`else
        csr_write(2'd1, 32'h20);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("e_no_s_req", {31'd0, bus.irq_req}, 32'd0);
        end
        check("e_to_s_zero", {31'd0, bus.irq_to_s}, 32'd0);
        csr_read("e_mideleg_zero", 2'd2, 32'h0);
`endif
        csr_write(2'd1, 32'h0);
        csr_write(2'd0, 32'h0);
        csr_write(2'd2, 32'h0);
        priv = 2'd3; mstatus_sie = 1'b0; mstatus_mie = 1'b1;

        // meip pulse through 3 sync stages, then reset mid-REQ.
        csr_write(2'd0, 32'h800);
        meip = 1'b1;
        exp_q.push_back({1'b0, 4'd11});
        tick();
        meip = 1'b0;
        check("f_lat1", {31'd0, bus.irq_req}, 32'd0);
        tick();
        check("f_lat2", {31'd0, bus.irq_req}, 32'd0);
        tick();
        check("f_lat3", {31'd0, bus.irq_req}, 32'd0);
        tick();
        check("f_lat4", {31'd0, bus.irq_req}, 32'd1);
        resetn = 1'b0;
        tick();
        check("f_rst_req", {31'd0, bus.irq_req}, 32'd0);
        check("f_rst_cause", {28'd0, bus.irq_cause}, 32'd0);
        csr_read("f_rst_mie", 2'd0, 32'h0);
        resetn = 1'b1;
        repeat (3) tick();

        check("sb_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_arbiter.md
IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth for meip (legal values 2..4).
REQ-002 The block SHALL have port clk, input, 1, meaning the system clock.
REQ-003 The block SHALL have port resetn, input, 1, meaning the reset; resetn is synchronous and active-low, and the clock is clk.
REQ-004 The block SHALL have port msip, input, 1, meaning the machine software interrupt from the timer/IPI unit (synchronous to clk).
REQ-005 The block SHALL have port mtip, input, 1, meaning the machine timer interrupt from the timer/IPI unit (synchronous to clk).
REQ-006 The block SHALL have port meip, input, 1, meaning the machine external interrupt (asynchronous).
REQ-007 The block SHALL have port csr_we, input, 1, meaning the CSR write strobe.
REQ-008 The block SHALL have port csr_sel, input, 2, meaning the register select: 0 mie, 1 mip, 2 mideleg, 3 reserved.
REQ-009 The block SHALL have port csr_wdata, input, 32, meaning the CSR write data.
REQ-010 The block SHALL have port csr_rdata, output, 32, meaning the combinational read of the selected register (reserved reads 0).
REQ-011 The block SHALL have port mstatus_mie, input, 1, meaning the global M-mode interrupt enable.
REQ-012 The block SHALL have port mstatus_sie, input, 1, meaning the global S-mode interrupt enable.
REQ-013 The block SHALL have port priv, input, 2, meaning the current privilege (0 U, 1 S, 3 M).
REQ-014 The block SHALL have port irq_ack, input, 1, meaning the core takes the trap this cycle.
REQ-015 The block SHALL have port irq_req, output, 1, meaning a registered interrupt request.
REQ-016 The block SHALL have port irq_cause, output, 4, meaning the registered cause code of the request.
REQ-017 The block SHALL have port irq_to_s, output, 1, meaning the request targets S-mode (delegated).

Function
REQ-018 meip SHALL pass through SYNC_STAGES flops; msip and mtip SHALL NOT be synchronized.
REQ-019 mip[3], mip[7] and mip[11] SHALL be read-only and reflect msip, mtip and synchronized meip respectively; writes to these bits SHALL be ignored.
REQ-020 mie SHALL implement writable bits 3, 7 and 11 (plus the S bits under REQ-031); all other bits SHALL read 0.
REQ-021 Each interrupt i SHALL be active when mip[i] and mie[i] are both set.
REQ-022 A non-delegated active interrupt SHALL be eligible when priv!=3 or mstatus_mie=1.
REQ-023 The fixed priority SHALL be, highest first: 11, 3, 7, 9, 1, 5.
REQ-024 The state machine SHALL have states IDLE, REQ and HOLD. IDLE goes to REQ when any interrupt is eligible, latching the winner into irq_cause/irq_to_s. REQ goes to HOLD on irq_ack. REQ goes to IDLE if nothing is eligible (withdrawal). HOLD goes to IDLE unconditionally after 1 cycle.
REQ-025 irq_req SHALL be 1 exactly in REQ, and irq_cause SHALL be stable while in REQ even if a higher-priority source arrives; the new source is re-arbitrated after HOLD.
REQ-026 Latency SHALL be: msip/mtip rising to irq_req=1 in 1 cycle (registered); meip rising to irq_req=1 in SYNC_STAGES+1 cycles.
REQ-027 irq_ack while not in REQ SHALL be ignored.
REQ-028 A CSR write and an ack in the same cycle SHALL both take effect; arbitration SHALL use the pre-write register values for that cycle.

Reset
REQ-029 With resetn=0 at a clk edge, the block SHALL clear mie, mideleg, the writable mip bits, the sync flops, irq_req, irq_cause and irq_to_s to 0 and enter IDLE.
REQ-030 Reset asserted in REQ SHALL drop irq_req on the next edge, with no ack required.

Configuration
REQ-031 With macro IRQ_ARBITER_SUPERVISOR_EN defined: mip bits 1/5/9 are software-writable; mie bits 1/5/9 are writable; mideleg bits 1/5/9 are writable. A delegated active interrupt is eligible when priv=0, or priv=1 and mstatus_sie=1, and is never eligible at priv=3. irq_to_s=1 for delegated winners.
REQ-032 Without IRQ_ARBITER_SUPERVISOR_EN: bits 1/5/9 of mie/mip, and all of mideleg, SHALL read 0 and ignore writes; mstatus_sie SHALL be ignored; irq_to_s SHALL be held at 0.

Verification
REQ-033 mie=0x80, mstatus_mie=1, priv=3, mtip 0->1 -> irq_req=1 the next cycle with cause=7; ack -> irq_req=0 for at least 1 cycle.
REQ-034 mie=0x888 with msip, mtip and meip all high -> cause=11 first; after ack and HOLD -> cause=3; then -> cause=7.
REQ-035 priv=3, mstatus_mie=0, msip=1, mie=0x8 -> irq_req stays 0; switching priv to 0 -> irq_req=1 with cause=3 the next cycle.
REQ-036 While in REQ with cause=7, write mie=0 -> irq_req=0 the following cycle; write mip=0xFFFFFFFF -> bits 3/7/11 unchanged.
REQ-037 With SUPERVISOR_EN, mideleg=0x20, mie=0x20, mip[5]=1, priv=1, sie=1 -> cause=5 and irq_to_s=1; with priv=3 -> no request.
REQ-038 meip pulse with SYNC_STAGES=3 -> irq_req rises exactly 4 cycles later; resetn low mid-REQ -> irq_req=0 at the next edge.
